// File: rtl/program_loader_if.sv
// Loader-side signal bundle: control, byte-stream handshake and memory write port.
// master = loader, slave = stream source / memory / CPU side.
interface program_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        input  start, in_valid, in_byte,
        output in_ready, mem_waddr, mem_wdata, mem_wen, cpu_hold, done, error
    );

    modport slave (
        output start, in_valid, in_byte,
        input  in_ready, mem_waddr, mem_wdata, mem_wen, cpu_hold, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Streams a little-endian program image (header N + N words) into main memory
// and holds the CPU in reset until the whole image has landed.
module program_loader #(
    parameter int DEPTH     = 2048,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    localparam logic [31:0] CAP  = 32'(DEPTH - BASE_ADDR);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    state_t      state, state_nx;
    logic [1:0]  byte_cnt;
    logic        hdr_full;
    logic [31:0] count;
    logic [31:0] word_idx;
    logic [23:0] wbuf;
    logic [31:0] waddr_q, wdata_q;
    logic        rdy;
    logic        accept;

    // The cycle after the 4th header byte is the decision cycle; no byte is
    // taken then so a 5th byte cannot be swallowed into the header.
    always_comb begin
        rdy      = 1'b0;
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (bus.start) state_nx = HDR;
            HDR: begin
                rdy = !hdr_full;
                if (hdr_full) begin
                    if (count == 32'd0)  state_nx = DONE;
                    else if (count > CAP) state_nx = ERR;
                    else                  state_nx = DATA;
                end
            end
            DATA: begin
                rdy = 1'b1;
                if (bus.in_valid && byte_cnt == 2'd3) state_nx = WRITE;
            end
            WRITE: state_nx = (word_idx + 32'd1 == count) ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = bus.in_valid & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            hdr_full <= 1'b0;
            count    <= 32'd0;
            word_idx <= 32'd0;
            wbuf     <= 24'd0;
            waddr_q  <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE, ERR: if (bus.start) begin
                    byte_cnt <= 2'd0;
                    hdr_full <= 1'b0;
                    count    <= 32'd0;
                    word_idx <= 32'd0;
                end
                HDR: begin
                    if (hdr_full) hdr_full <= 1'b0;
                    else if (accept) begin
                        // shift in from the top: byte 0 ends up in bits [7:0]
                        count    <= {bus.in_byte, count[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) hdr_full <= 1'b1;
                    end
                end
                DATA: if (accept) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wdata_q <= {bus.in_byte, wbuf};
                        waddr_q <= BASE + word_idx;
                    end else begin
                        wbuf <= {bus.in_byte, wbuf[23:8]};
                    end
                end
                WRITE: word_idx <= word_idx + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mem_wen   = (state == WRITE);
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_hold  = (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.error     = (state == ERR);
endmodule
